decoder_rr_arbiter: RTL and testbench

// - Round-robin arbiter that shares one 3-to-8 decoded select resource among 8 requesters.
// - Selects one requester and registers its 3-bit index.
// - Drives the one-hot grant as the decoded index (d0..d7 style), bounded by a hold limit.
// - Sits between requester blocks and the shared decode/function datapath.

---
 rtl/decoder_rr_arbiter_if.sv | 24 ++
 rtl/decoder_rr_arbiter.sv | 145 ++++++++++++++
 tb/tb_decoder_rr_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between the requester blocks and the decoded-select arbiter.
// Build option: DEC_ARB_MASK_EN adds the per-requester enable vector req_mask.
//
// Handshake: req[i] is a level request from requester i. It is granted while
// gnt_vld=1 and gnt_idx=i, with gnt=one-hot(i). Each requester keeps req[i]
// high for as long as it wants the resource and drops it to release. There is
// no separate ready signal: the grant itself is the acceptance.
interface decoder_rr_arbiter_if;
  logic [7:0] req;
`ifdef DEC_ARB_MASK_EN
  logic [7:0] req_mask;
`endif
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;

`ifdef DEC_ARB_MASK_EN
  modport master (output req, output req_mask, input gnt, input gnt_idx, input gnt_vld);
  modport slave  (input req, input req_mask, output gnt, output gnt_idx, output gnt_vld);
`else
  modport master (output req, input gnt, input gnt_idx, input gnt_vld);
  modport slave  (input req, output gnt, output gnt_idx, output gnt_vld);
`endif
endinterface

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 decoded select among 8 requesters.
// The owner's index is registered and the grant is its decoded one-hot form.
// A hold limit stops one owner from keeping the grant while others wait.
// Build option: DEC_ARB_MASK_EN enables req_mask gating of the requests.
module decoder_rr_arbiter #(
  parameter int unsigned MAX_HOLD   = 4,
  parameter int unsigned HOLD_CNT_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  decoder_rr_arbiter_if.slave   bus,
  output logic [0:0]            dbg_state
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // Hold limit in counter width. With no limit the counter still saturates
  // (at all-ones) so it can never wrap.
  localparam logic [HOLD_CNT_W-1:0] HOLD_LIM = HOLD_CNT_W'(MAX_HOLD);
  localparam logic [HOLD_CNT_W-1:0] HOLD_SAT = (MAX_HOLD == 0) ? '1 : HOLD_LIM;

  logic [0:0]            state, nxt_state;
  logic [2:0]            ptr, nxt_ptr;
  logic [HOLD_CNT_W-1:0] hold_cnt, nxt_hold;
  logic [2:0]            nxt_idx;
  logic                  nxt_vld;
  logic [7:0]            nxt_gnt;

  logic [7:0]            ereq;
  logic [7:0]            owner_oh;
  logic [7:0]            others;
  logic                  owner_held;
  logic                  do_grant;
  logic [7:0]            cand;
  logic [2:0]            win;

  // First set bit of e, scanning p+1, p+2, ... and wrapping 7->0.
  function automatic logic [2:0] rr_pick(input logic [7:0] e, input logic [2:0] p);
    logic [2:0] idx;
    logic       found;
    rr_pick = p;
    found   = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = p + 3'(k);
      if (!found && e[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // Effective request vector and owner-relative views of it.
  always_comb begin
`ifdef DEC_ARB_MASK_EN
    ereq = bus.req & bus.req_mask;
`else
    ereq = bus.req;
`endif
    owner_oh   = 8'h01 << bus.gnt_idx;
    others     = ereq & ~owner_oh;
    owner_held = ereq[bus.gnt_idx];
  end

  // Winner among the candidate set, searched from just after the last grant.
  always_comb begin
    win = rr_pick(cand, ptr);
  end

  // Next-state decision: idle, keep the owner, or hand over to a new winner.
  always_comb begin
    nxt_state = state;
    nxt_ptr   = ptr;
    nxt_hold  = hold_cnt;
    nxt_idx   = bus.gnt_idx;
    nxt_vld   = bus.gnt_vld;
    do_grant  = 1'b0;
    cand      = 8'h00;

    case (state)
      IDLE: begin
        if (ereq != 8'h00) begin
          do_grant = 1'b1;
          cand     = ereq;
        end
      end
      GRANT: begin
        if (!owner_held) begin
          // Owner released (or masked off): hand over with no idle bubble.
          if (others != 8'h00) begin
            do_grant = 1'b1;
            cand     = others;
          end else begin
            nxt_state = IDLE;
          end
        end else if ((others != 8'h00) && (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM)) begin
          // Owner used up its slot while others wait: rotate past it.
          do_grant = 1'b1;
          cand     = others;
        end else if (hold_cnt != HOLD_SAT) begin
          nxt_hold = hold_cnt + HOLD_CNT_W'(1);
        end
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase

    if (do_grant) begin
      nxt_state = GRANT;
      nxt_idx   = win;
      nxt_vld   = 1'b1;
      nxt_hold  = HOLD_CNT_W'(1);
      nxt_ptr   = win;
    end else if (nxt_state == IDLE) begin
      nxt_idx  = 3'd0;
      nxt_vld  = 1'b0;
      nxt_hold = '0;
    end

    nxt_gnt = nxt_vld ? (8'h01 << nxt_idx) : 8'h00;
  end

  // Registered state and outputs; reset parks the pointer at 7 so the first search starts at 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 3'd7;
      hold_cnt    <= '0;
      bus.gnt     <= 8'h00;
      bus.gnt_idx <= 3'd0;
      bus.gnt_vld <= 1'b0;
    end else begin
      state       <= nxt_state;
      ptr         <= nxt_ptr;
      hold_cnt    <= nxt_hold;
      bus.gnt     <= nxt_gnt;
      bus.gnt_idx <= nxt_idx;
      bus.gnt_vld <= nxt_vld;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Bench for decoder_rr_arbiter: directed scenarios plus randomized requests
// checked every cycle against a behavioural arbitration model.
module tb_decoder_rr_arbiter;

  localparam int TB_MAX_HOLD = 4;

  // Clock and reset
  logic clk;
  logic rst_n;
  logic [0:0] dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  decoder_rr_arbiter_if arb_if ();

  decoder_rr_arbiter #(
    .MAX_HOLD   (TB_MAX_HOLD),
    .HOLD_CNT_W (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (arb_if),
    .dbg_state (dbg_state)
  );

  // Scoreboard state
  int n_checks;
  int n_errors;
  logic [7:0] exp_q[$];
  logic [7:0] cur_mask;

  // Behavioural model: owner, how long it has held, last granted index.
  bit m_vld;
  int m_idx;
  int m_ptr;
  int m_held;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_pick(input logic [7:0] e);
    for (int k = 1; k <= 8; k++) begin
      int i;
      i = (m_ptr + k) % 8;
      if (e[i]) begin
        m_idx  = i;
        m_ptr  = i;
        m_vld  = 1'b1;
        m_held = 1;
        return;
      end
    end
  endtask

  task automatic model_step(input logic [7:0] r, input logic rn);
    logic [7:0] e;
    logic [7:0] others;
    logic [7:0] exp_gnt;
    if (!rn) begin
      m_vld  = 1'b0;
      m_idx  = 0;
      m_ptr  = 7;
      m_held = 0;
    end else begin
      e = r & cur_mask;
      if (m_vld && e[m_idx]) begin
        others = e;
        others[m_idx] = 1'b0;
        if ((others != 8'h00) && (m_held >= TB_MAX_HOLD))
          model_pick(others);
        else
          m_held++;
      end else if (e != 8'h00) begin
        model_pick(e);
      end else begin
        m_vld  = 1'b0;
        m_idx  = 0;
        m_held = 0;
      end
    end
    exp_gnt = 8'h00;
    if (m_vld) exp_gnt[m_idx] = 1'b1;
    exp_q.push_back(exp_gnt);
  endtask

  // Driver: apply one cycle of inputs, advance the model, check after the edge.
  task automatic cycle(input logic [7:0] r, input logic rn);
    logic [7:0] exp_gnt;
    @(negedge clk);
    arb_if.req = r;
`ifdef DEC_ARB_MASK_EN
    arb_if.req_mask = cur_mask;
`endif
    rst_n = rn;
    model_step(r, rn);
    @(posedge clk);
    #1;
    exp_gnt = exp_q.pop_front();
    check_eq("gnt", 32'(arb_if.gnt), 32'(exp_gnt));
    check_eq("gnt_idx", 32'(arb_if.gnt_idx), 32'(m_idx));
    check_eq("gnt_vld", 32'(arb_if.gnt_vld), 32'(m_vld));
    check_eq("state", 32'(dbg_state), 32'(m_vld));
    check_eq("onehot", 32'($countones(arb_if.gnt) <= 1), 32'(1));
  endtask

  task automatic do_reset();
    cycle(8'h00, 1'b0);
    cycle(8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] r;
    int owner;
    n_checks = 0;
    n_errors = 0;
    cur_mask = 8'hFF;
    rst_n = 1'b0;
    arb_if.req = 8'h00;
`ifdef DEC_ARB_MASK_EN
    arb_if.req_mask = 8'hFF;
`endif
    m_vld = 1'b0; m_idx = 0; m_ptr = 7; m_held = 0;

    // Reset state, then a single request from requester 0
    do_reset();
    check_eq("rst_gnt", 32'(arb_if.gnt), 32'h00);
    cycle(8'h01, 1'b1);
    check_eq("first_gnt", 32'(arb_if.gnt), 32'h01);

    // All requesting: each owner gets exactly TB_MAX_HOLD cycles, then wrap
    do_reset();
    for (int n = 0; n <= 32; n++) begin
      cycle(8'hFF, 1'b1);
      check_eq("ff_rotation", 32'(arb_if.gnt), 32'(1) << ((n / TB_MAX_HOLD) % 8));
    end

    // Owner release hands over with no empty cycle
    do_reset();
    cycle(8'h24, 1'b1);
    check_eq("own2", 32'(arb_if.gnt_idx), 32'd2);
    cycle(8'h24, 1'b1);
    cycle(8'h24, 1'b1);
    cycle(8'h20, 1'b1);
    check_eq("handover", 32'(arb_if.gnt), 32'h20);

    // Lone requester keeps the grant indefinitely
    do_reset();
    for (int n = 0; n < 20; n++) begin
      cycle(8'h80, 1'b1);
      check_eq("lone80", 32'(arb_if.gnt), 32'h80);
    end
    cycle(8'h00, 1'b1);
    check_eq("lone_release", 32'(arb_if.gnt), 32'h00);

    // Reset mid-grant, then the first grant restarts at index 0
    do_reset();
    for (int n = 0; n < 22; n++) cycle(8'hFF, 1'b1);
    check_eq("owner5", 32'(arb_if.gnt_idx), 32'd5);
    cycle(8'hFF, 1'b0);
    check_eq("midrst_gnt", 32'(arb_if.gnt), 32'h00);
    cycle(8'hFF, 1'b1);
    check_eq("post_rst_gnt", 32'(arb_if.gnt), 32'h01);

`ifdef DEC_ARB_MASK_EN
    // Masked requester 0 never granted; rotation runs over 1..7
    do_reset();
    cur_mask = 8'hFE;
    for (int n = 0; n < 30; n++) begin
      cycle(8'hFF, 1'b1);
      check_eq("mask_idx", 32'(arb_if.gnt_idx), 32'(1 + (n / TB_MAX_HOLD) % 7));
      check_eq("mask_bit0", 32'(arb_if.gnt[0]), 32'd0);
    end
    owner = int'(arb_if.gnt_idx);
    cur_mask[owner] = 1'b0;
    cycle(8'hFF, 1'b1);
    check_eq("mask_owner", 32'(arb_if.gnt_idx), 32'((owner + 1) % 8));
    cur_mask = 8'hFF;
`endif

    // Randomized traffic with occasional resets
    do_reset();
    r = 8'h00;
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 7))
        0: r = 8'($urandom_range(0, 255));
        1, 2: r = r ^ (8'h01 << $urandom_range(0, 7));
        default: ;
      endcase
`ifdef DEC_ARB_MASK_EN
      if ($urandom_range(0, 7) == 0) cur_mask = 8'($urandom_range(0, 255));
`endif
      cycle(r, ($urandom_range(0, 99) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
